// File: rtl/feature_line_buffer.sv
// rtl/feature_line_buffer.sv - banked row buffer between the feature-map loader and data_router
//
// Purpose: absorbs a raster pixel stream into NBANK banks of NROW x BUFW words and
// serves POY-row, column-shifted, optionally padded windows to the router.
// Banks are released in order by blkend.
// Optional macro: FLB_PROTOCOL_CHK_EN enables the sticky protocol checker on err.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready  loader write stream
//   rd_en/bank/row/col/rpsel   read request (window select, column shift, padding)
//   blkend                 release oldest FULL bank
//   data/rd_vld            registered read window and its one-cycle valid
//   bank_rdy/rd_bank       read-pointer bank FULL, read pointer
//   err                    sticky protocol error (0 without the checker)
module feature_line_buffer #(
    parameter int DW    = 32,
    parameter int POY   = 3,
    parameter int BUFW  = 48,
    parameter int NROW  = 4,
    parameter int NBANK = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_valid,
    input  logic [DW-1:0]                        wr_data,
    output logic                                 wr_ready,
    input  logic                                 rd_en,
    input  logic [1:0]                           bank,
    input  logic [1:0]                           row,
    input  logic [27:0]                          col,
    input  logic [1:0]                           rpsel,
    input  logic                                 blkend,
    output logic [POY-1:0][BUFW-1:0][DW-1:0]     data,
    output logic                                 rd_vld,
    output logic                                 bank_rdy,
    output logic [1:0]                           rd_bank,
    output logic                                 err
);

    localparam int CW = $clog2(BUFW);
    localparam int RW = $clog2(NROW);
    // NBANK is a power of two, so masking implements the modulo-NBANK pointers.
    localparam logic [1:0] PMASK = 2'(NBANK - 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_state_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} wr_state_t;

    bank_state_t bst [NBANK];
    wr_state_t   state;
    logic [1:0]  wp;
    logic [1:0]  rp;
    logic [CW-1:0] ccnt;
    logic [RW-1:0] rcnt;
    logic [DW-1:0] mem [NBANK][NROW][BUFW];

    logic accept;
    logic last_word;
    logic release_ok;
    logic [1:0] rb;
    logic [POY-1:0][BUFW-1:0][DW-1:0] win;

    assign rb         = bank & PMASK;
    assign accept     = (state == S_FILL) && wr_valid;
    assign last_word  = accept && (rcnt == RW'(NROW - 1)) && (ccnt == CW'(BUFW - 1));
    assign release_ok = blkend && (bst[rp] == B_FULL);

    assign wr_ready = rst_n && (state == S_FILL);
    assign bank_rdy = (bst[rp] == B_FULL);
    assign rd_bank  = rp;

    // Write FSM and bank bookkeeping. The bank completed by the writer is always
    // FILLING, while a released bank is FULL, so both updates never target the
    // same bank on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wp    <= '0;
            rp    <= '0;
            ccnt  <= '0;
            rcnt  <= '0;
            for (int i = 0; i < NBANK; i++) begin
                bst[i] <= B_EMPTY;
            end
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    if (bst[wp] == B_EMPTY) begin
                        bst[wp] <= B_FILLING;
                        state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (ccnt == CW'(BUFW - 1)) begin
                            ccnt <= '0;
                            rcnt <= rcnt + 1'b1;
                        end else begin
                            ccnt <= ccnt + 1'b1;
                        end
                        if (last_word) begin
                            bst[wp] <= B_FULL;
                            wp      <= (wp + 2'd1) & PMASK;
                            rcnt    <= '0;
                            state   <= S_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (release_ok) begin
                bst[rp] <= B_EMPTY;
                rp      <= (rp + 2'd1) & PMASK;
            end
        end
    end

    // Storage carries no reset: a reset empties every bank, so stale contents
    // are never served to a correct requester.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wp][rcnt][ccnt] <= wr_data;
        end
    end

    // Window: row index wraps inside the bank, columns shift left by col and
    // fill with zeros past the end of the row.
    always_comb begin
        logic [28:0] cx;
        cx  = '0;
        win = '0;
        for (int y = 0; y < POY; y++) begin
            for (int x = 0; x < BUFW; x++) begin
                cx = {1'b0, col} + 29'(x);
                if ((cx < 29'(BUFW)) &&
                    !((y == 0) && rpsel[0]) &&
                    !((y == POY - 1) && rpsel[1])) begin
                    win[y][x] = mem[rb][RW'(int'(row) + y)][cx[CW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                data <= win;
            end
        end
    end

`ifdef FLB_PROTOCOL_CHK_EN
    logic pend;
    logic err_q;

    // pend: a word was offered last cycle and not taken, so the loader must hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pend <= wr_valid && !wr_ready;
            if ((rd_en && (bst[rb] != B_FULL)) ||
                (blkend && (bst[rp] != B_FULL)) ||
                (pend && !wr_valid && !wr_ready)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_feature_line_buffer.sv
// tb/tb_feature_line_buffer.sv - self-checking bench for feature_line_buffer
module tb_feature_line_buffer;

    localparam int DW    = 32;
    localparam int POY   = 3;
    localparam int BUFW  = 48;
    localparam int NROW  = 4;
    localparam int NBANK = 4;
    localparam int NWORD = NROW * BUFW;

    typedef logic [POY-1:0][BUFW-1:0][DW-1:0] win_t;

    typedef struct {
        logic [1:0]  b;
        logic [1:0]  r;
        logic [27:0] c;
        logic [1:0]  ps;
        int          y;
        int          x;
        logic [31:0] val;
    } rv_t;

    typedef struct {
        win_t        win;
        int          y;
        int          x;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [DW-1:0] wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [1:0]  bank;
    logic [1:0]  row;
    logic [27:0] col;
    logic [1:0]  rpsel;
    logic        blkend;
    win_t        data;
    logic        rd_vld;
    logic        bank_rdy;
    logic [1:0]  rd_bank;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [NBANK][NROW][BUFW];
    exp_t sbq[$];
    exp_t mon_e;
    win_t last_win;
    rv_t  tbl [16];
    bit   chk_en;

    always #5 clk = ~clk;

    feature_line_buffer #(
        .DW(DW), .POY(POY), .BUFW(BUFW), .NROW(NROW), .NBANK(NBANK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .bank(bank), .row(row), .col(col), .rpsel(rpsel),
        .blkend(blkend),
        .data(data), .rd_vld(rd_vld), .bank_rdy(bank_rdy), .rd_bank(rd_bank),
        .err(err)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic win_t model_win(input logic [1:0] b, input logic [1:0] r,
                                       input logic [27:0] c, input logic [1:0] ps);
        win_t w = '0;
        for (int y = 0; y < POY; y++) begin
            for (int x = 0; x < BUFW; x++) begin
                longint idx = longint'(c) + x;
                bit pad = (y == 0 && ps[0]) || (y == POY - 1 && ps[1]);
                if (idx < BUFW && !pad) begin
                    w[y][x] = model[b][(int'(r) + y) % NROW][int'(idx)];
                end
            end
        end
        return w;
    endfunction

    // Scoreboard: each rd_vld pops the window pushed when the request was driven.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_vld === 1'b1) begin
            if (sbq.size() == 0) begin
                check("rd_vld_unexpected", 64'(rd_vld), 64'd0);
            end else begin
                bit found = 0;
                mon_e = sbq.pop_front();
                checks++;
                if (data !== mon_e.win) begin
                    failures++;
                    for (int y = 0; y < POY; y++) begin
                        for (int x = 0; x < BUFW; x++) begin
                            if (!found && data[y][x] !== mon_e.win[y][x]) begin
                                found = 1;
                                $display("FAIL window y=%0d x=%0d actual=%0h required=%0h",
                                         y, x, data[y][x], mon_e.win[y][x]);
                            end
                        end
                    end
                end
                check("spot_value", 64'(data[mon_e.y][mon_e.x]), 64'(mon_e.val));
                last_win = mon_e.win;
            end
        end
    end

    task automatic put(input logic [DW-1:0] v);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = v;
        while (wr_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (wr_ready !== 1'b1) begin
            check("put_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic fill(input int b, input int base, input bit blk_last, input bit chk_rdy);
        for (int k = 0; k < NWORD; k++) begin
            if (k == NWORD - 1) begin
                if (chk_rdy) check("bank_rdy_before_last", 64'(bank_rdy), 64'd0);
                if (blk_last) blkend = 1'b1;
            end
            put(DW'(base + k));
            model[b][k / BUFW][k % BUFW] = DW'(base + k);
        end
        blkend = 1'b0;
    endtask

    task automatic do_read(input rv_t v);
        exp_t e;
        rd_en = 1'b1;
        bank  = v.b;
        row   = v.r;
        col   = v.c;
        rpsel = v.ps;
        e.win = model_win(v.b, v.r, v.c, v.ps);
        e.y   = v.y;
        e.x   = v.x;
        e.val = v.val;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        rd_en = 1'b0;
        while (sbq.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
`ifdef FLB_PROTOCOL_CHK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        tbl[0]  = '{2'd0, 2'd1, 28'd0,         2'd0, 0, 0,  32'd48};
        tbl[1]  = '{2'd0, 2'd1, 28'd0,         2'd0, 2, 47, 32'd191};
        tbl[2]  = '{2'd0, 2'd3, 28'd45,        2'd0, 0, 0,  32'd189};
        tbl[3]  = '{2'd0, 2'd3, 28'd45,        2'd0, 1, 0,  32'd45};
        tbl[4]  = '{2'd0, 2'd3, 28'd45,        2'd0, 0, 3,  32'd0};
        tbl[5]  = '{2'd0, 2'd0, 28'd0,         2'd3, 1, 0,  32'd48};
        tbl[6]  = '{2'd0, 2'd0, 28'd0,         2'd3, 0, 5,  32'd0};
        tbl[7]  = '{2'd0, 2'd2, 28'd47,        2'd0, 0, 0,  32'd143};
        tbl[8]  = '{2'd0, 2'd2, 28'd48,        2'd0, 1, 0,  32'd0};
        tbl[9]  = '{2'd0, 2'd1, 28'hFFFFFFF,   2'd0, 0, 0,  32'd0};
        tbl[10] = '{2'd0, 2'd0, 28'd0,         2'd1, 2, 0,  32'd96};
        tbl[11] = '{2'd0, 2'd1, 28'd0,         2'd2, 0, 0,  32'd48};
        tbl[12] = '{2'd2, 2'd2, 28'd10,        2'd0, 1, 0,  32'd2154};
        tbl[13] = '{2'd3, 2'd3, 28'd0,         2'd0, 0, 47, 32'd3191};
        tbl[14] = '{2'd0, 2'd0, 28'd0,         2'd0, 0, 0,  32'd5000};
        tbl[15] = '{2'd3, 2'd1, 28'd1,         2'd0, 2, 46, 32'd3191};

        rst_n = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0;
        bank = '0; row = '0; col = '0; rpsel = '0; blkend = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",     64'(data == '0), 64'd1);
        check("rst_rd_vld",   64'(rd_vld),   64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_bank_rdy", 64'(bank_rdy), 64'd0);
        check("rst_rd_bank",  64'(rd_bank),  64'd0);
        check("rst_err",      64'(err),      64'd0);

        rst_n = 1'b1;
        check("wr_ready_cycle1", 64'(wr_ready), 64'd0);
        @(negedge clk);
        check("wr_ready_cycle2", 64'(wr_ready), 64'd1);

        fill(0, 0, 1'b0, 1'b1);
        check("bank_rdy_after_fill", 64'(bank_rdy), 64'd1);
        check("rd_bank_after_fill",  64'(rd_bank),  64'd0);

        for (int i = 0; i < 12; i++) do_read(tbl[i]);
        drain();
        @(negedge clk);
        check("hold_rd_vld", 64'(rd_vld), 64'd0);
        check("hold_data",   64'(data == last_win), 64'd1);

        fill(1, 1000, 1'b0, 1'b0);
        fill(2, 2000, 1'b0, 1'b0);
        fill(3, 3000, 1'b0, 1'b0);

        // All banks FULL: a presented word must stay unaccepted.
        begin
            int hi = 0;
            wr_valid = 1'b1;
            wr_data  = 32'd5000;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (wr_ready !== 1'b0) hi++;
            end
            check("full_wr_ready_low", 64'(hi), 64'd0);
        end
        blkend = 1'b1;
        @(negedge clk);
        blkend = 1'b0;
        check("release_rd_bank",  64'(rd_bank),  64'd1);
        check("release_bank_rdy", 64'(bank_rdy), 64'd1);
        check("release_wr_ready_1cyc", 64'(wr_ready), 64'd0);
        @(negedge clk);
        check("release_wr_ready_2cyc", 64'(wr_ready), 64'd1);

        // Refill bank 0 starting with the held word; release bank 1 on the final word.
        fill(0, 5000, 1'b1, 1'b0);
        check("simul_rd_bank",   64'(rd_bank),  64'd2);
        check("simul_bank_rdy",  64'(bank_rdy), 64'd1);
        check("simul_wr_ready0", 64'(wr_ready), 64'd0);
        @(negedge clk);
        check("simul_wr_ready1", 64'(wr_ready), 64'd1);

        for (int i = 12; i < 16; i++) do_read(tbl[i]);
        drain();

        // Reset mid-operation, then a blkend with nothing FULL.
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_bank_rdy", 64'(bank_rdy), 64'd0);
        check("rst2_rd_bank",  64'(rd_bank),  64'd0);
        check("rst2_wr_ready", 64'(wr_ready), 64'd0);
        check("rst2_data",     64'(data == '0), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_err", 64'(err), 64'd0);
        blkend = 1'b1;
        @(negedge clk);
        blkend = 1'b0;
        check("blkend_rd_bank_unchanged", 64'(rd_bank), 64'd0);
        check("err_set", 64'(err), 64'(chk_en));
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(err), 64'(chk_en));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
